tdoa_capture_sequencer: RTL and testbench

TDOA_CAPTURE_SEQUENCER -- requirements
Module: tdoa_capture_sequencer

---
 rtl/tdoa_capture_sequencer.sv | 143 ++++++++++++++
 tb/tb_tdoa_capture_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdoa_capture_sequencer.sv
// Four-hydrophone arrival-time capture sequencer producing delays relative to hydrophone 0.
// Define TDOA_HOLDOFF_EN to add a post-result dead time of HOLDOFF cycles.
module tdoa_capture_sequencer #(
  parameter int unsigned TS_W    = 16,
  parameter int unsigned TIMEOUT = 4000,
  parameter int unsigned HOLDOFF = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic [3:0]      hit,
  output logic            busy,
  output logic            delay_valid,
  input  logic            delay_ready,
  output logic [TS_W-1:0] delay_1,
  output logic [TS_W-1:0] delay_2,
  output logic [TS_W-1:0] delay_3,
  output logic [3:0]      ch_mask,
  output logic            timeout
);

  localparam logic [TS_W-1:0] LastCnt = TS_W'(TIMEOUT - 1);

`ifdef TDOA_HOLDOFF_EN
  typedef enum logic [2:0] {StIdle, StArmed, StWindow, StDone, StHoldoff} state_e;
  localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  logic [HoldW-1:0] hcnt_q, hcnt_d;
`else
  typedef enum logic [2:0] {StIdle, StArmed, StWindow, StDone} state_e;
`endif

  state_e                 state_q, state_d;
  logic [TS_W-1:0]        cnt_q, cnt_d;
  logic [3:0][TS_W-1:0]   ts_q, ts_d;
  logic [3:0]             mask_q, mask_d;
  logic                   timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ts_d      = ts_q;
    mask_d    = mask_q;
    timeout_d = timeout_q;
`ifdef TDOA_HOLDOFF_EN
    hcnt_d    = hcnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (arm) begin
          state_d   = StArmed;
          cnt_d     = '0;
          ts_d      = '0;
          mask_d    = '0;
          timeout_d = 1'b0;
        end
      end
      StArmed: begin
        // Timestamps were cleared on arm, so channels hit now already hold 0.
        if (|hit) begin
          mask_d = hit;
          cnt_d  = TS_W'(1);
          if (&hit) begin
            state_d = StDone;
          end else if (TIMEOUT <= 1) begin
            state_d   = StDone;
            timeout_d = 1'b1;
          end else begin
            state_d = StWindow;
          end
        end
      end
      StWindow: begin
        for (int k = 0; k < 4; k++) begin
          if (hit[k] && !mask_q[k]) begin
            ts_d[k] = cnt_q;
          end
        end
        mask_d = mask_q | hit;
        // Captures in the final window cycle count before the timeout decision.
        if (&mask_d) begin
          state_d = StDone;
        end else if (cnt_q == LastCnt) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TS_W'(1);
        end
      end
      StDone: begin
        if (delay_ready) begin
`ifdef TDOA_HOLDOFF_EN
          hcnt_d  = '0;
          state_d = (HOLDOFF == 0) ? StIdle : StHoldoff;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef TDOA_HOLDOFF_EN
      StHoldoff: begin
        if (hcnt_q == HoldW'(HOLDOFF - 1)) begin
          state_d = StIdle;
        end else begin
          hcnt_d = hcnt_q + HoldW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ts_q      <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
`ifdef TDOA_HOLDOFF_EN
      hcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ts_q      <= ts_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
`ifdef TDOA_HOLDOFF_EN
      hcnt_q    <= hcnt_d;
`endif
    end
  end

  // All outputs derive from registers only.
  assign busy        = (state_q != StIdle);
  assign delay_valid = (state_q == StDone);
  assign ch_mask     = mask_q;
  assign timeout     = timeout_q;
  assign delay_1     = (mask_q[1] && mask_q[0]) ? ts_q[1] - ts_q[0] : '0;
  assign delay_2     = (mask_q[2] && mask_q[0]) ? ts_q[2] - ts_q[0] : '0;
  assign delay_3     = (mask_q[3] && mask_q[0]) ? ts_q[3] - ts_q[0] : '0;

endmodule

// File: tb/tb_tdoa_capture_sequencer.sv
// Scoreboard bench for tdoa_capture_sequencer: stimulus pushes expected results,
// a monitor pops and compares on every accepted result.
module tb_tdoa_capture_sequencer;

  localparam int TS_W = 16;
  localparam int TO   = 40;
  localparam int HO   = 6;

  logic            clk = 1'b0;
  logic            rst, arm, delay_ready;
  logic [3:0]      hit;
  logic            busy, delay_valid, timeout;
  logic [TS_W-1:0] delay_1, delay_2, delay_3;
  logic [3:0]      ch_mask;

  tdoa_capture_sequencer #(
    .TS_W   (TS_W),
    .TIMEOUT(TO),
    .HOLDOFF(HO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .hit        (hit),
    .busy       (busy),
    .delay_valid(delay_valid),
    .delay_ready(delay_ready),
    .delay_1    (delay_1),
    .delay_2    (delay_2),
    .delay_3    (delay_3),
    .ch_mask    (ch_mask),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] d3;
    logic [3:0]  m;
    logic        t;
  } res_t;

  res_t exp_q[$];
  res_t exp_e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted result is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && delay_valid && delay_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got result with mask %0h, expected none", ch_mask);
      end else begin
        exp_e = exp_q.pop_front();
        chk("delay_1", delay_1, exp_e.d1);
        chk("delay_2", delay_2, exp_e.d2);
        chk("delay_3", delay_3, exp_e.d3);
        chk("ch_mask", ch_mask, exp_e.m);
        chk("timeout", timeout, exp_e.t);
      end
    end
  end

  // Arm, then drive hit schedule t[k] (-1 = never) for window cycles 0..last.
  // With lvl set, a channel stays high after its first hit.
  task automatic capture(input int t0, input int t1, input int t2, input int t3,
                         input int last, input bit lvl);
    int t[4];
    t = '{t0, t1, t2, t3};
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    for (int n = 0; n <= last; n++) begin
      for (int k = 0; k < 4; k++) begin
        hit[k] = lvl ? (t[k] >= 0 && n >= t[k]) : (t[k] == n);
      end
      if (n == last) chk("valid_before_last", delay_valid, 0);
      cyc();
    end
    hit = 4'h0;
    chk("latency_valid", delay_valid, 1);
  endtask

  task automatic accept_and_idle();
    cyc();
`ifdef TDOA_HOLDOFF_EN
    repeat (HO) cyc();
`endif
    chk("idle_after_accept", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; hit = 4'h0; delay_ready = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", delay_valid, 0);
    chk("rst_d1", delay_1, 0);
    chk("rst_mask", ch_mask, 0);
    chk("rst_timeout", timeout, 0);

    // Hits in IDLE are ignored.
    hit = 4'hF;
    repeat (3) cyc();
    hit = 4'h0;
    chk("idle_hit_busy", busy, 0);
    chk("idle_hit_valid", delay_valid, 0);

    exp_q.push_back('{16'd5, 16'd12, 16'd3, 4'hF, 1'b0});
    capture(0, 5, 12, 3, 12, 1'b0);
    accept_and_idle();

    exp_q.push_back('{16'd0, 16'd0, 16'd0, 4'hF, 1'b0});
    capture(0, 0, 0, 0, 0, 1'b0);
    accept_and_idle();

    exp_q.push_back('{16'hFFF9, 16'd0, 16'd0, 4'b0011, 1'b1});
    capture(7, 0, -1, -1, TO - 1, 1'b1);
    accept_and_idle();

    // Last channel captured in the final window cycle: no timeout.
    exp_q.push_back('{16'd1, 16'd1, 16'd39, 4'hF, 1'b0});
    capture(0, 1, 1, TO - 1, TO - 1, 1'b0);
    accept_and_idle();

    // Channel 0 never captured: delays forced to zero.
    exp_q.push_back('{16'd0, 16'd0, 16'd0, 4'b0110, 1'b1});
    capture(-1, 0, TO - 1, -1, TO - 1, 1'b0);
    accept_and_idle();

    // Consumer stalls for 10 cycles while hit and arm toggle.
    delay_ready = 1'b0;
    exp_q.push_back('{16'd2, 16'd1, 16'd4, 4'hF, 1'b0});
    capture(0, 2, 1, 4, 4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      hit = 4'($urandom);
      arm = i[0];
      chk("stall_valid", delay_valid, 1);
      chk("stall_d1", delay_1, 2);
      chk("stall_d2", delay_2, 1);
      chk("stall_d3", delay_3, 4);
      chk("stall_mask", ch_mask, 4'hF);
      cyc();
    end
    hit = 4'h0; arm = 1'b0; delay_ready = 1'b1;
    cyc();
    chk("stall_drop_valid", delay_valid, 0);
`ifndef TDOA_HOLDOFF_EN
    chk("stall_idle", busy, 0);
`else
    repeat (HO) cyc();
    chk("stall_idle", busy, 0);
`endif

    // Reset mid-window.
    arm = 1'b1; cyc(); arm = 1'b0;
    hit = 4'b0001; cyc();
    hit = 4'b0000; cyc();
    hit = 4'b0010; cyc();
    hit = 4'b0000; cyc();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", delay_valid, 0);
    chk("mid_rst_d1", delay_1, 0);
    chk("mid_rst_mask", ch_mask, 0);
    chk("mid_rst_timeout", timeout, 0);
    rst = 1'b1; arm = 1'b1; hit = 4'hF; cyc();
    rst = 1'b0; arm = 1'b0; hit = 4'h0;
    chk("rst_priority_busy", busy, 0);
    exp_q.push_back('{16'd1, 16'd2, 16'd3, 4'hF, 1'b0});
    capture(0, 1, 2, 3, 3, 1'b0);
    accept_and_idle();

`ifdef TDOA_HOLDOFF_EN
    exp_q.push_back('{16'd0, 16'd0, 16'd0, 4'hF, 1'b0});
    capture(0, 0, 0, 0, 0, 1'b0);
    arm = 1'b1;
    cyc();
    for (int i = 0; i < HO; i++) begin
      chk("holdoff_busy", busy, 1);
      chk("holdoff_valid", delay_valid, 0);
      cyc();
    end
    chk("holdoff_exit", busy, 0);
    cyc();
    arm = 1'b0;
    chk("holdoff_arm_taken", busy, 1);
    exp_q.push_back('{16'd0, 16'd0, 16'd0, 4'hF, 1'b0});
    hit = 4'hF; cyc(); hit = 4'h0;
    chk("holdoff_rearm_valid", delay_valid, 1);
    accept_and_idle();
`endif

    repeat (3) cyc();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
